// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared types for the debug SPI slave/master pair: the frame
//           state enum and the latched mode word (cpol, cpha, lsbf).
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsbf;
  } spi_mode_t;

  localparam spi_mode_t c_mode_reset = '{cpol: 1'b0, cpha: 1'b0, lsbf: 1'b0};

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync / spi_sync_edge
// Purpose : spi_sync is a bare STAGES-deep synchronizer for an asynchronous
//           pin. spi_sync_edge adds one history flop behind it and produces
//           single-cycle rise/fall pulses.
// Ports   : clk, rst_n (async, active-low), d (async pin),
//           q (synchronized level, spi_sync only),
//           rise / fall (one-cycle edge pulses, spi_sync_edge only)
// Revision: 1.0  initial release
// ============================================================================
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{RST_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic w_q;
  logic r_hist;

  spi_sync #(.STAGES(STAGES), .RST_VAL(RST_VAL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (w_q)
  );

  // History resets to the same idle level so no edge is reported out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hist <= RST_VAL;
    else        r_hist <= w_q;
  end

  assign rise = w_q & ~r_hist;
  assign fall = ~w_q & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_slave_debug.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_debug
// Purpose : Oversampled SPI slave for the debug bus. Runtime-selectable
//           CPOL/CPHA and bit order, multi-word frames, one-cycle rx_valid,
//           wdata_ack and frame_err pulses.
// Ports   : clk, rst_n (async, active-low)
//           sclk, nss, mosi       asynchronous SPI pins
//           miso, miso_oe         slave data out and pad enable
//           cpol, cpha, lsbf      mode, latched at frame start
//           wdata / wdata_ack     next tx word, sampled while ack is high
//           rdata / rx_valid      last received word and its update pulse
//           frame_err             nss released mid-word
//           busy                  frame in progress
// Revision: 1.0  initial release
// ============================================================================
module spi_slave_debug
  import spi_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 nss,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsbf,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic                 wdata_ack,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(BIT_WIDTH + 1);

  logic w_sclk_rise, w_sclk_fall, w_nss_rise, w_nss_fall, w_mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk (clk), .rst_n (rst_n), .d (sclk), .rise (w_sclk_rise), .fall (w_sclk_fall)
  );

  // nss idles high, so its synchronizer resets high to avoid a false frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss_sync (
    .clk (clk), .rst_n (rst_n), .d (nss), .rise (w_nss_rise), .fall (w_nss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk (clk), .rst_n (rst_n), .d (mosi), .q (w_mosi)
  );

  spi_state_t           r_state, w_state_nxt;
  spi_mode_t            r_mode;
  logic [CW-1:0]        r_bcnt, w_bcnt_nxt;
  logic [CW-1:0]        r_tidx;
  logic [BIT_WIDTH-1:0] r_rx, w_rx_nxt;
  logic [BIT_WIDTH-1:0] r_tx;
  logic [BIT_WIDTH-1:0] r_rdata;
  logic                 r_miso, r_rx_valid, r_frame_err;
  logic                 w_lead, w_trail, w_sample, w_shift;
  logic                 w_start, w_word_done, w_frame_err;

  // Bit idx of a word in transmit order; shifting avoids an oversized index.
  function automatic logic tx_bit(input logic [BIT_WIDTH-1:0] w,
                                  input logic [CW-1:0] idx,
                                  input logic lsb);
    logic [BIT_WIDTH-1:0] t;
    t = lsb ? (w >> idx) : (w << idx);
    return lsb ? t[0] : t[BIT_WIDTH-1];
  endfunction

  assign w_lead   = r_mode.cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = r_mode.cpol ? w_sclk_rise : w_sclk_fall;
  assign w_rx_nxt = r_mode.lsbf ? {w_mosi, r_rx[BIT_WIDTH-1:1]}
                                : {r_rx[BIT_WIDTH-2:0], w_mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_word_done = 1'b0;
    w_frame_err = 1'b0;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (w_nss_fall) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        w_sample    = r_mode.cpha ? w_trail : w_lead;
        w_shift     = r_mode.cpha ? w_lead  : w_trail;
        w_word_done = w_sample && (r_bcnt == CW'(BIT_WIDTH - 1));
        if (w_word_done)   w_bcnt_nxt = '0;
        else if (w_sample) w_bcnt_nxt = r_bcnt + CW'(1);
        // A sample coinciding with nss rise is counted first, so a word that
        // completes on that edge ends the frame cleanly.
        if (w_nss_rise) begin
          w_state_nxt = IDLE;
          w_frame_err = (w_bcnt_nxt != '0);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= c_mode_reset;
      r_bcnt      <= '0;
      r_tidx      <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rdata     <= '0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_word_done;
      r_frame_err <= w_frame_err;
      if (w_start) begin
        r_mode <= '{cpol: cpol, cpha: cpha, lsbf: lsbf};
        r_bcnt <= '0;
        r_rx   <= '0;
        r_tx   <= wdata;
        // Bit 0 goes out immediately; for cpha=1 it is re-driven on the
        // first leading edge, so the index starts at 0 in that mode.
        r_miso <= tx_bit(wdata, '0, lsbf);
        r_tidx <= cpha ? CW'(0) : CW'(1);
      end else if (r_state == ACTIVE) begin
        r_bcnt <= w_bcnt_nxt;
        if (w_sample) r_rx <= w_rx_nxt;
        if (w_word_done) begin
          r_rdata <= w_rx_nxt;
          r_tx    <= wdata;
          r_tidx  <= '0;
        end else if (w_shift && (r_tidx < CW'(BIT_WIDTH))) begin
          r_miso <= tx_bit(r_tx, r_tidx, r_mode.lsbf);
          r_tidx <= r_tidx + CW'(1);
        end
      end
    end
  end

  assign busy      = (r_state == ACTIVE);
  assign miso_oe   = busy;
  assign miso      = busy & r_miso;
  assign wdata_ack = w_start | w_word_done;
  assign rdata     = r_rdata;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/spi_slave_debug.md
# spi_slave_debug

SPI slave (responder) for the debug SPI bus. It receives MOSI words from an external master and returns MISO words on the same frame. Mode (CPOL/CPHA) and bit order are selectable at runtime. The block oversamples the asynchronous SPI pins with the system clock, delivers each received word with a one-cycle valid pulse, and requests the next transmit word with a one-cycle acknowledge pulse.

## Interface
Parameters:
- BIT_WIDTH, 16, word length in bits (2..32)
- SYNC_STAGES, 2, synchronizer flops on sclk/nss/mosi (≥2)

Ports:
- clk  in  1  system clock; must be ≥ 8× the SCLK frequency
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock from master, asynchronous
- nss  in  1  slave select, active-low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  tri-state enable for the miso pad; high while selected
- cpol, cpha, lsbf  in  1 each  mode controls; latched at frame start
- wdata  in  BIT_WIDTH  next word to transmit
- wdata_ack  out  1  pulse: wdata was latched this cycle
- rdata  out  BIT_WIDTH  last complete received word
- rx_valid  out  1  pulse: rdata updated
- frame_err  out  1  pulse: nss deasserted mid-word
- busy  out  1  high while a frame is in progress

## Operation
- sclk, nss and mosi each pass through SYNC_STAGES flops, plus one history flop for edge detection on sclk and nss.
- Leading edge is the sclk transition away from the latched cpol; trailing edge is the transition back.
- Sample edge is the leading edge when cpha=0 and the trailing edge when cpha=1. Shift edge is the other one.
- State machine IDLE → ACTIVE:
  - IDLE→ACTIVE on a synced nss falling edge. In the same cycle: latch cpol/cpha/lsbf, load the tx shift register from wdata, pulse wdata_ack, set bcnt=0.
  - ACTIVE→IDLE on a synced nss rising edge.
- Receive, on each sample edge in ACTIVE:
  - Shift in synced mosi: MSB-first when lsbf=0, LSB-first when lsbf=1.
  - Increment bcnt.
  - When bcnt reaches BIT_WIDTH: copy the assembled word to rdata, pulse rx_valid, wrap bcnt to 0, reload the tx register from wdata, pulse wdata_ack. Multi-word frames are unlimited.
- Transmit:
  - cpha=0: bit 0 of a word is driven at frame start (first word) or at the trailing edge after the previous word's last sample. Bit k (k≥1) is driven at the trailing edge after bit k−1 is sampled.
  - cpha=1: bit k is driven at the k-th leading edge of the word.
  - Bit order follows lsbf.
- miso_oe = busy. miso is forced to 0 in IDLE.
- nss rising with bcnt≠0: pulse frame_err, no rx_valid, discard the partial word, return to IDLE.
- nss rising with bcnt=0: silent return to IDLE.
- Sclk edges while in IDLE are ignored. cpol/cpha/lsbf changes during ACTIVE are ignored.

## Timing
- Reset values:
  - miso=0, miso_oe=0, busy=0, rdata=0
  - rx_valid=0, wdata_ack=0, frame_err=0
  - state=IDLE, bcnt=0, shift registers=0
- Pin-to-detection latency is SYNC_STAGES+1 clk (3 at default).
- rx_valid rises 1 clk after the detected last sample edge and is high for exactly 1 clk. rdata is stable from that cycle until the next word completes.
- wdata must be valid while wdata_ack is high. It is sampled in that cycle only.
- miso updates 1 clk after the detected shift edge. busy rises 1 clk after detected nss fall.
- Master constraints:
  - ≥4 clk between nss fall and the first sclk edge.
  - ≥4 clk per SCLK half-period.
- Simultaneous nss rise and last sample edge: the sample completes first (rx_valid pulses), then return to IDLE with no frame_err.
- Simultaneous nss fall while returning to IDLE: not supported. The master must hold nss high for ≥4 clk.
- Async reset mid-frame: all outputs return to reset values immediately. The next frame starts only on a fresh nss fall.

## Structure
- spi_pkg holds the shared state enum (IDLE/ACTIVE) and the mode struct {cpol, cpha, lsbf}; spi_master_debug adopts the same package.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchronizer with rise/fall pulse outputs. Instantiate it for sclk and nss; instantiate a bare synchronizer for mosi.

## Test plan
- Mode 0, lsbf=0, wdata=16'hA5C3, master sends 16'h1234 → rdata=16'h1234 with one rx_valid; master captures 16'hA5C3; one wdata_ack.
- Mode 3, lsbf=1, wdata=16'h8001, master sends 16'h00FF → rdata=16'h00FF; master captures 16'h8001.
- Modes 1 and 2, back-to-back 3-word frame, wdata sequence 16'h1111/16'h2222/16'h3333 → three rx_valid, four wdata_ack, MISO words returned in order.
- nss deasserted after 7 bits → one frame_err, no rx_valid, rdata unchanged, busy=0 within 4 clk.
- rst_n asserted at bit 9 → all outputs at reset values. The next full frame with 16'hBEEF yields rdata=16'hBEEF.
- Sclk toggling while nss=1, with a cpol change while ACTIVE → no rx_valid, no miso activity, mode unchanged until the next frame.
